// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// and the datapath select codes the controller emits.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_ADDR  = 2'b11;

  localparam logic [1:0] RD_RT  = 2'b00;
  localparam logic [1:0] RD_RD  = 2'b01;
  localparam logic [1:0] RD_R31 = 2'b10;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BRANCH, S_JUMP, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    CLS_EXEC, CLS_BRANCH, CLS_JUMP, CLS_ILLEGAL
  } op_class_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory bundle. master = controller, slave = datapath side.
interface mips_multicycle_ctrl_if #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int CNT_W    = 16
);
  logic                run;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_ready;
  logic                pc_write;
  logic                ir_write;
  logic                branch;
  logic                jump;
  logic                mem_read;
  logic                mem_write;
  logic                reg_write;
  logic [1:0]          reg_dst;
  logic [1:0]          memto_reg;
  logic                alu_src;
  logic [ALU_OP_W-1:0] alu_op;
  logic                sign_or_zero;
  logic                instr_done;
  logic                illegal_op;
  logic                bus_error;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  run, opcode, mem_ready,
    output pc_write, ir_write, branch, jump, mem_read, mem_write, reg_write,
           reg_dst, memto_reg, alu_src, alu_op, sign_or_zero, instr_done,
           illegal_op, bus_error, instr_count
  );

  modport slave (
    output run, opcode, mem_ready,
    input  pc_write, ir_write, branch, jump, mem_read, mem_write, reg_write,
           reg_dst, memto_reg, alu_src, alu_op, sign_or_zero, instr_done,
           illegal_op, bus_error, instr_count
  );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// memory ready handshake, wait timeout to a sticky ERROR state, and retire counter.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 2,
  parameter int TIMEOUT  = 15,
  parameter int CNT_W    = 16
) (
  input logic                    clk,
  input logic                    reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t              state, state_next;
  logic [OPCODE_W-1:0] op_q;
  logic [CW-1:0]       wait_cnt;
  logic                waiting, tmo;

  function automatic op_class_t op_class(input logic [OPCODE_W-1:0] op);
    if (op == OPCODE_W'(OP_R) || op == OPCODE_W'(OP_ADDI) ||
        op == OPCODE_W'(OP_LW) || op == OPCODE_W'(OP_SW))
      return CLS_EXEC;
    else if (op == OPCODE_W'(OP_BEQ))
      return CLS_BRANCH;
    else if (op == OPCODE_W'(OP_J) || op == OPCODE_W'(OP_JAL))
      return CLS_JUMP;
    else
      return CLS_ILLEGAL;
  endfunction

  // mem_ready on the TIMEOUT-th low-wait cycle still completes the access
  assign waiting = (state == S_FETCH) || (state == S_MEM);
  assign tmo     = waiting && !bus.mem_ready && (wait_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      op_q            <= '0;
      wait_cnt        <= '0;
      bus.instr_count <= '0;
    end else begin
      state <= state_next;
      if (state == S_DECODE) op_q <= bus.opcode;
      wait_cnt <= (waiting && !bus.mem_ready && state_next == state) ? wait_cnt + CW'(1) : '0;
      if (bus.instr_done) bus.instr_count <= bus.instr_count + CNT_W'(1);
    end
  end

  always_comb begin
    state_next       = state;
    bus.pc_write     = 1'b0;
    bus.ir_write     = 1'b0;
    bus.branch       = 1'b0;
    bus.jump         = 1'b0;
    bus.mem_read     = 1'b0;
    bus.mem_write    = 1'b0;
    bus.reg_write    = 1'b0;
    bus.reg_dst      = RD_RT;
    bus.memto_reg    = M2R_ALU;
    bus.alu_src      = 1'b0;
    bus.alu_op       = ALU_OP_W'(ALU_ADD);
    bus.sign_or_zero = 1'b1;
    bus.instr_done   = 1'b0;
    bus.illegal_op   = 1'b0;
    bus.bus_error    = 1'b0;
    case (state)
      S_IDLE: if (bus.run) state_next = S_FETCH;
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_next   = S_DECODE;
        end else if (tmo) state_next = S_ERROR;
      end
      S_DECODE: begin
        case (op_class(bus.opcode))
          CLS_EXEC:   state_next = S_EXEC;
          CLS_BRANCH: state_next = S_BRANCH;
          CLS_JUMP:   state_next = S_JUMP;
          default: begin
            bus.illegal_op = 1'b1;
            state_next     = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        if (op_q == OPCODE_W'(OP_R)) begin
          bus.alu_op = ALU_OP_W'(ALU_FUNCT);
          state_next = S_WB;
        end else if (op_q == OPCODE_W'(OP_ADDI)) begin
          bus.alu_src = 1'b1;
          state_next  = S_WB;
        end else begin
          bus.alu_op  = ALU_OP_W'(ALU_ADDR);
          bus.alu_src = 1'b1;
          state_next  = S_MEM;
        end
      end
      S_MEM: begin
        bus.mem_read  = (op_q == OPCODE_W'(OP_LW));
        bus.mem_write = (op_q != OPCODE_W'(OP_LW));
        if (bus.mem_ready) begin
          if (op_q == OPCODE_W'(OP_LW)) state_next = S_WB;
          else begin
            bus.instr_done = 1'b1;
            state_next     = S_FETCH;
          end
        end else if (tmo) state_next = S_ERROR;
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        if (op_q == OPCODE_W'(OP_R))  bus.reg_dst   = RD_RD;
        if (op_q == OPCODE_W'(OP_LW)) bus.memto_reg = M2R_MEM;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        bus.branch     = 1'b1;
        bus.alu_op     = ALU_OP_W'(ALU_SUB);
        bus.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_JUMP: begin
        bus.jump       = 1'b1;
        bus.pc_write   = 1'b1;
        bus.instr_done = 1'b1;
        if (op_q == OPCODE_W'(OP_JAL)) begin
          bus.reg_write = 1'b1;
          bus.reg_dst   = RD_R31;
          bus.memto_reg = M2R_PC4;
        end
        state_next = S_FETCH;
      end
      S_ERROR: bus.bus_error = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed-vector bench: stimulus pushes hand-computed per-cycle expectations,
// a negedge monitor pops and compares them against the controller outputs.
module tb_mips_multicycle_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mips_multicycle_ctrl_if #(.OPCODE_W(6), .ALU_OP_W(2), .CNT_W(4)) ifc ();

  mips_multicycle_ctrl #(.OPCODE_W(6), .ALU_OP_W(2), .TIMEOUT(15), .CNT_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (ifc.master)
  );

  // bits: pcw irw br jmp mr mw rw rd[2] m2r[2] asrc aop[2] soz done ill berr
  localparam logic [17:0] E_IDLE    = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_FETCH_W = 18'b0_0_0_0_1_0_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_FETCH_R = 18'b1_1_0_0_1_0_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_DEC     = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_DEC_ILL = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_1_0;
  localparam logic [17:0] E_EX_R    = 18'b0_0_0_0_0_0_0_00_00_0_10_1_0_0_0;
  localparam logic [17:0] E_EX_ADDI = 18'b0_0_0_0_0_0_0_00_00_1_00_1_0_0_0;
  localparam logic [17:0] E_EX_MEM  = 18'b0_0_0_0_0_0_0_00_00_1_11_1_0_0_0;
  localparam logic [17:0] E_MEM_LW  = 18'b0_0_0_0_1_0_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_MEM_SW  = 18'b0_0_0_0_0_1_0_00_00_0_00_1_0_0_0;
  localparam logic [17:0] E_MEM_SWD = 18'b0_0_0_0_0_1_0_00_00_0_00_1_1_0_0;
  localparam logic [17:0] E_WB_R    = 18'b0_0_0_0_0_0_1_01_00_0_00_1_1_0_0;
  localparam logic [17:0] E_WB_ADDI = 18'b0_0_0_0_0_0_1_00_00_0_00_1_1_0_0;
  localparam logic [17:0] E_WB_LW   = 18'b0_0_0_0_0_0_1_00_01_0_00_1_1_0_0;
  localparam logic [17:0] E_BRANCH  = 18'b0_0_1_0_0_0_0_00_00_0_01_1_1_0_0;
  localparam logic [17:0] E_JUMP_J  = 18'b1_0_0_1_0_0_0_00_00_0_00_1_1_0_0;
  localparam logic [17:0] E_JUMP_AL = 18'b1_0_0_1_0_0_1_10_10_0_00_1_1_0_0;
  localparam logic [17:0] E_ERR     = 18'b0_0_0_0_0_0_0_00_00_0_00_1_0_0_1;

  localparam logic [5:0] O_R = 6'b000000, O_ADDI = 6'b001000, O_LW = 6'b100011,
                         O_SW = 6'b101011, O_BEQ = 6'b000100, O_J = 6'b000010,
                         O_JAL = 6'b000011, O_BAD = 6'b111111;

  typedef struct {
    logic [17:0] sig;
    logic [3:0]  cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [17:0] actual();
    return {ifc.pc_write, ifc.ir_write, ifc.branch, ifc.jump, ifc.mem_read,
            ifc.mem_write, ifc.reg_write, ifc.reg_dst, ifc.memto_reg, ifc.alu_src,
            ifc.alu_op, ifc.sign_or_zero, ifc.instr_done, ifc.illegal_op, ifc.bus_error};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [17:0] a;
      e = q.pop_front();
      a = actual();
      n_cmp++;
      if (a !== e.sig) begin
        n_bad++;
        $display("FAIL %s strobes: got %b expected %b", e.name, a, e.sig);
      end
      n_cmp++;
      if (ifc.instr_count !== e.cnt) begin
        n_bad++;
        $display("FAIL %s instr_count: got %0d expected %0d", e.name, ifc.instr_count, e.cnt);
      end
    end
  end

  task automatic step(input logic rst, input logic rn, input logic [5:0] op,
                      input logic rdy, input logic [17:0] sig, input int cnt,
                      input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset         = rst;
    ifc.run       = rn;
    ifc.opcode    = op;
    ifc.mem_ready = rdy;
    e.sig  = sig;
    e.cnt  = 4'(cnt);
    e.name = name;
    q.push_back(e);
  endtask

  initial begin
    reset         = 1'b1;
    ifc.run       = 1'b0;
    ifc.opcode    = '0;
    ifc.mem_ready = 1'b0;

    repeat (3) step(1, 0, O_R, 0, E_IDLE, 0, "reset");

    // R-type, immediate memory
    step(0, 1, O_R, 1, E_IDLE,    0, "r_idle");
    step(0, 1, O_R, 1, E_FETCH_R, 0, "r_fetch");
    step(0, 1, O_R, 1, E_DEC,     0, "r_decode");
    step(0, 1, O_R, 1, E_EX_R,    0, "r_exec");
    step(0, 1, O_R, 1, E_WB_R,    0, "r_wb");

    // lw with two wait cycles in MEM
    step(0, 1, O_R,  1, E_FETCH_R, 1, "lw_fetch");
    step(0, 1, O_LW, 1, E_DEC,     1, "lw_decode");
    step(0, 1, O_LW, 1, E_EX_MEM,  1, "lw_exec");
    step(0, 1, O_LW, 0, E_MEM_LW,  1, "lw_mem_w1");
    step(0, 1, O_LW, 0, E_MEM_LW,  1, "lw_mem_w2");
    step(0, 1, O_LW, 1, E_MEM_LW,  1, "lw_mem_rdy");
    step(0, 1, O_LW, 1, E_WB_LW,   1, "lw_wb");

    step(0, 1, O_JAL, 1, E_FETCH_R, 2, "jal_fetch");
    step(0, 1, O_JAL, 1, E_DEC,     2, "jal_decode");
    step(0, 1, O_JAL, 1, E_JUMP_AL, 2, "jal_jump");

    step(0, 0, O_BEQ, 1, E_FETCH_R, 3, "beq_fetch");
    step(0, 0, O_BEQ, 1, E_DEC,     3, "beq_decode");
    step(0, 0, O_BEQ, 1, E_BRANCH,  3, "beq_branch");

    step(0, 0, O_BAD, 1, E_FETCH_R, 4, "ill_fetch");
    step(0, 0, O_BAD, 1, E_DEC_ILL, 4, "ill_decode");

    step(0, 0, O_ADDI, 1, E_FETCH_R, 4, "addi_fetch");
    step(0, 0, O_ADDI, 1, E_DEC,     4, "addi_decode");
    step(0, 0, O_ADDI, 1, E_EX_ADDI, 4, "addi_exec");
    step(0, 0, O_ADDI, 1, E_WB_ADDI, 4, "addi_wb");

    step(0, 0, O_SW, 1, E_FETCH_R, 5, "sw_fetch");
    step(0, 0, O_SW, 1, E_DEC,     5, "sw_decode");
    step(0, 0, O_SW, 1, E_EX_MEM,  5, "sw_exec");
    step(0, 0, O_SW, 0, E_MEM_SW,  5, "sw_mem_w");
    step(0, 0, O_SW, 1, E_MEM_SWD, 5, "sw_mem_rdy");

    // ready arriving on the 15th wait cycle still completes the fetch
    for (int i = 0; i < 14; i++) step(0, 0, O_J, 0, E_FETCH_W, 6, "edge_wait");
    step(0, 0, O_J, 1, E_FETCH_R, 6, "edge_rdy15");
    step(0, 0, O_J, 1, E_DEC,     6, "edge_decode");
    step(0, 0, O_J, 1, E_JUMP_J,  6, "edge_jump");

    // 15 low cycles -> sticky bus error
    for (int i = 0; i < 15; i++) step(0, 0, O_J, 0, E_FETCH_W, 7, "tmo_wait");
    step(0, 1, O_J, 0, E_ERR, 7, "tmo_err");
    step(0, 1, O_J, 1, E_ERR, 7, "tmo_sticky");
    step(1, 1, O_J, 1, E_ERR, 7, "tmo_rst_cyc");
    step(0, 0, O_J, 1, E_IDLE, 0, "tmo_cleared");
    step(0, 1, O_J, 1, E_IDLE, 0, "idle_go");

    // 16 jumps wrap the 4-bit counter
    for (int i = 0; i < 16; i++) begin
      step(0, 0, O_J, 1, E_FETCH_R, i, "wrap_fetch");
      step(0, 0, O_J, 1, E_DEC,     i, "wrap_decode");
      step(0, 0, O_J, 1, E_JUMP_J,  i, "wrap_jump");
    end

    // reset during sw MEM wait aborts the store
    step(0, 0, O_SW, 1, E_FETCH_R, 0, "swr_fetch");
    step(0, 0, O_SW, 1, E_DEC,     0, "swr_decode");
    step(0, 0, O_SW, 1, E_EX_MEM,  0, "swr_exec");
    step(1, 0, O_SW, 0, E_MEM_SW,  0, "swr_mem_rst");
    step(0, 0, O_SW, 1, E_IDLE,    0, "swr_after");
    step(0, 0, O_SW, 1, E_IDLE,    0, "swr_idle");

    @(posedge clk);
    @(negedge clk);
    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
